// File: rtl/rr_sel_mux_if.sv
// Handshake bundle between NCH producers, the selector, and one consumer.
// master = producer/consumer side, slave = selector side.
interface rr_sel_mux_if #(
    parameter int WIDTH = 32'd8,
    parameter int NCH   = 32'd4,
    parameter int CW    = $clog2(NCH)
);
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic [NCH*WIDTH-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic [CW-1:0]        out_ch;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );
endinterface

// File: rtl/rr_sel_mux.sv
// NCH-channel registered selector with fixed-priority or round-robin arbitration.
// One output register stage holding the winning word and its source channel index.
module rr_sel_mux #(
    parameter int WIDTH = 32'd8,
    parameter int NCH   = 32'd4,
    parameter int RR    = 32'd1,
    parameter int CW    = $clog2(NCH)
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_sel_mux_if.slave   bus
);

    logic [CW-1:0]    ptr_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    logic [CW-1:0]    out_ch_r;

    logic [CW:0]      search_idx_s;
    logic [CW-1:0]    grant_idx_s;
    logic             grant_vld_s;
    logic [NCH-1:0]   grant_s;
    logic             can_load_s;
    logic [NCH-1:0]   in_ready_s;
    logic             xfer_s;
    logic [WIDTH-1:0] sel_data_s;
    logic [CW-1:0]    ptr_next_s;

    // Search for the first valid channel starting at ptr, wrapping modulo NCH.
    // With RR=0 ptr stays at 0, so this degenerates to lowest-index priority.
    always_comb begin
        search_idx_s = {(CW+1){1'b0}};
        grant_idx_s  = {CW{1'b0}};
        grant_vld_s  = 1'b0;
        for (int k = 32'sd0; k < NCH; k++) begin
            search_idx_s = {1'b0, ptr_r} + (CW+1)'(k);
            if (search_idx_s >= (CW+1)'(NCH)) begin
                search_idx_s = search_idx_s - (CW+1)'(NCH);
            end else begin
                search_idx_s = search_idx_s;
            end
            if (!grant_vld_s && bus.in_valid[search_idx_s[CW-1:0]]) begin
                grant_vld_s = 1'b1;
                grant_idx_s = search_idx_s[CW-1:0];
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
    end

    // One-hot grant, ready gating and data selection for the winning channel.
    always_comb begin
        grant_s = {NCH{1'b0}};
        if (grant_vld_s) begin
            grant_s[grant_idx_s] = 1'b1;
        end else begin
            grant_s = {NCH{1'b0}};
        end
        can_load_s = !out_valid_r || bus.out_ready;
        in_ready_s = grant_s & {NCH{can_load_s & rst_n}};
        xfer_s     = |(bus.in_valid & in_ready_s);
        sel_data_s = bus.in_data[int'(grant_idx_s)*WIDTH +: WIDTH];
    end

    // Pointer advances past the winner; explicit wrap keeps non-power-of-two NCH in range.
    always_comb begin
        if (grant_idx_s == CW'(NCH - 1)) begin
            ptr_next_s = {CW{1'b0}};
        end else begin
            ptr_next_s = grant_idx_s + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // Output register stage and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {WIDTH{1'b0}};
            out_ch_r    <= {CW{1'b0}};
            ptr_r       <= {CW{1'b0}};
        end else if (xfer_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= sel_data_s;
            out_ch_r    <= grant_idx_s;
            if (RR != 32'sd0) begin
                ptr_r <= ptr_next_s;
            end else begin
                ptr_r <= {CW{1'b0}};
            end
        end else if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_ch    = out_ch_r;

endmodule

// File: tb/tb_rr_sel_mux.sv
// Directed bench for rr_sel_mux: RR=1/NCH=4, RR=0/NCH=4 and RR=1/NCH=3 instances.
module tb_rr_sel_mux;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    rr_sel_mux_if #(.WIDTH(8), .NCH(4)) a_if ();
    rr_sel_mux_if #(.WIDTH(8), .NCH(4)) b_if ();
    rr_sel_mux_if #(.WIDTH(8), .NCH(3)) c_if ();

    rr_sel_mux #(.WIDTH(8), .NCH(4), .RR(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
    rr_sel_mux #(.WIDTH(8), .NCH(4), .RR(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));
    rr_sel_mux #(.WIDTH(8), .NCH(3), .RR(1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(c_if.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        a_if.in_valid = 4'b1111; a_if.in_data = 32'h0; a_if.out_ready = 1'b1;
        b_if.in_valid = 4'b0000; b_if.in_data = 32'h0; b_if.out_ready = 1'b1;
        c_if.in_valid = 3'b000;  c_if.in_data = 24'h0; c_if.out_ready = 1'b1;

        // Reset state with all channels requesting
        #2;
        check_val("rst_out_valid", 32'(a_if.out_valid), 32'h0);
        check_val("rst_out_data",  32'(a_if.out_data),  32'h0);
        check_val("rst_out_ch",    32'(a_if.out_ch),    32'h0);
        check_val("rst_in_ready",  32'(a_if.in_ready),  32'h0);
        tick();
        tick();
        a_if.in_valid = 4'b0000;
        #2 rst_n = 1'b1;
        tick();

        // Single channel 2
        a_if.in_valid = 4'b0100;
        a_if.in_data  = {8'h00, 8'hA5, 8'h00, 8'h00};
        #1;
        check_val("single_in_ready", 32'(a_if.in_ready), 32'h4);
        tick();
        a_if.in_valid = 4'b0000;
        check_val("single_out_valid", 32'(a_if.out_valid), 32'h1);
        check_val("single_out_data",  32'(a_if.out_data),  32'hA5);
        check_val("single_out_ch",    32'(a_if.out_ch),    32'h2);

        // ptr now 3: all valid must grant channel 3 first
        a_if.in_valid = 4'b1111;
        a_if.in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        #1;
        check_val("ptr3_in_ready", 32'(a_if.in_ready), 32'h8);
        for (int k = 0; k < 8; k++) begin
            tick();
            check_val("rr_out_valid", 32'(a_if.out_valid), 32'h1);
            check_val("rr_out_ch",    32'(a_if.out_ch),    32'((3 + k) % 4));
            check_val("rr_out_data",  32'(a_if.out_data),  32'(8'h10 + ((3 + k) % 4)));
        end

        // ptr now 3: channel 0 only loads 3C, ptr -> 1
        a_if.in_valid = 4'b0001;
        a_if.in_data  = {8'h13, 8'h12, 8'h11, 8'h3C};
        tick();
        a_if.out_ready = 1'b0;
        a_if.in_valid  = 4'b1111;
        a_if.in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
        #1;
        check_val("bp_in_ready0", 32'(a_if.in_ready), 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_val("bp_out_valid", 32'(a_if.out_valid), 32'h1);
            check_val("bp_out_data",  32'(a_if.out_data),  32'h3C);
            check_val("bp_out_ch",    32'(a_if.out_ch),    32'h0);
            check_val("bp_in_ready",  32'(a_if.in_ready),  32'h0);
        end
        a_if.out_ready = 1'b1;
        #1;
        check_val("bp_release_ready", 32'(a_if.in_ready), 32'h2);
        tick();
        check_val("bp_next_ch",   32'(a_if.out_ch),   32'h1);
        check_val("bp_next_data", 32'(a_if.out_data), 32'h11);

        // Drain without a new load
        a_if.in_valid = 4'b0000;
        tick();
        check_val("drain_valid", 32'(a_if.out_valid), 32'h0);
        check_val("drain_data",  32'(a_if.out_data),  32'h11);
        check_val("drain_ch",    32'(a_if.out_ch),    32'h1);

        // Fixed priority: 1010 held -> channel 1 always
        b_if.in_valid = 4'b1010;
        b_if.in_data  = {8'h23, 8'h22, 8'h21, 8'h20};
        #1;
        check_val("fp_in_ready", 32'(b_if.in_ready), 32'h2);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_val("fp_out_ch",   32'(b_if.out_ch),   32'h1);
            check_val("fp_out_data", 32'(b_if.out_data), 32'h21);
        end
        b_if.in_valid = 4'b1000;
        tick();
        check_val("fp_ch3", 32'(b_if.out_ch),   32'h3);
        check_val("fp_d3",  32'(b_if.out_data), 32'h23);
        b_if.in_valid = 4'b0000;

        // NCH=3 wrap: 101 -> 0,2,0,2
        c_if.in_valid = 3'b101;
        c_if.in_data  = {8'h32, 8'h31, 8'h30};
        for (int k = 0; k < 4; k++) begin
            tick();
            check_val("wrap_out_ch",   32'(c_if.out_ch),   32'((k % 2) * 2));
            check_val("wrap_out_data", 32'(c_if.out_data), 32'(8'h30 + (k % 2) * 2));
        end
        c_if.in_valid = 3'b000;

        // Asynchronous reset while holding a word
        a_if.in_valid = 4'b0001;
        tick();
        a_if.in_valid = 4'b0000;
        a_if.out_ready = 1'b0;
        check_val("pre_arst_valid", 32'(a_if.out_valid), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_valid", 32'(a_if.out_valid), 32'h0);
        check_val("arst_data",  32'(a_if.out_data),  32'h0);
        tick();
        #2 rst_n = 1'b1;
        tick();
        check_val("post_arst_valid", 32'(a_if.out_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rr_sel_mux.md
Name: rr_sel_mux

Overview:
- Parametrised successor to the 2-input ternary selector. It is an NCH-channel, WIDTH-bit registered selector with per-channel valid/ready handshakes.
- Arbitration is fixed-priority or round-robin, chosen by parameter.
- The single output register stage carries the data plus the index of the winning channel.
- Sits between multiple producers and one consumer. Replaces ad-hoc ?: selection wherever more than two sources share one sink.

Parameters:
- WIDTH, 8, data width per channel (1..64).
- NCH, 4, number of input channels (2..16; any value, not restricted to powers of two).
- RR, 1, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin.
- CW, $clog2(NCH), width of channel index (derived; do not override).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  NCH  per-channel data valid
- in_ready  output  NCH  per-channel accept; combinational
- in_data  input  NCH*WIDTH  packed data; channel i at [i*WIDTH +: WIDTH]
- out_valid  output  1  output register holds a word
- out_ready  input  1  consumer accepts the output word
- out_data  output  WIDTH  registered selected data
- out_ch  output  CW  registered index of the source channel

Behaviour:
- Reset (asynchronous, rst_n=0):
  - out_valid=0, out_data=0, out_ch=0, priority pointer ptr=0.
  - in_ready=0 while rst_n=0.
  - Deassertion is sampled on the next clk edge.
  - Reset mid-transfer drops the held word; no replay after reset.
- can_load = !out_valid | out_ready. This is a combinational look-through, so there is no bubble on drain.
- Grant (combinational, one-hot or zero):
  - RR=0: lowest i with in_valid[i]=1.
  - RR=1: first i with in_valid[i]=1, searching from ptr upward modulo NCH (ptr, ptr+1, ..., NCH-1, 0, ..., ptr-1).
  - No valid inputs -> grant=0.
- in_ready[i] = grant[i] & can_load & rst_n. At most one in_ready is high per cycle.
- Transfer on channel g when in_valid[g] & in_ready[g]. At the next edge:
  - out_data <= in_data[g]
  - out_ch <= g
  - out_valid <= 1
  - RR=1 only: ptr <= (g==NCH-1) ? 0 : g+1. This wrap applies for non-power-of-two NCH too.
- Output drain: out_valid & out_ready & no transfer in the same cycle -> out_valid <= 0. out_data and out_ch hold their last values.
- Simultaneous drain and load in one cycle -> new word loaded, out_valid stays 1. Sustained throughput is 1 word/cycle.
- Stall: out_valid=1 & out_ready=0:
  - out_data and out_ch stay stable.
  - All in_ready=0.
  - ptr unchanged.
- Latency: 1 cycle from accepted input to out_valid.
- ptr changes only on a transfer. Idle cycles and stalls do not advance it.
- RR=0: ptr is held at 0 (unused).
- Source protocol: a producer holds in_valid and in_data until in_ready. The block does not check this. Dropping valid early simply loses the grant with no transfer.
- No combinational path from out_ready to out_valid or out_data.

Test Plan:
- Reset: rst_n=0 with in_valid=4'b1111, out_ready=1 -> out_valid=0, out_data=0, out_ch=0, in_ready=0. Assert rst_n=0 mid-stream with out_valid=1 -> out_valid drops to 0 immediately (asynchronous).
- Single channel: in_valid=4'b0100, in_data[2]=8'hA5, out_ready=1 -> in_ready=4'b0100. Next cycle: out_valid=1, out_data=8'hA5, out_ch=2. Then ptr=3.
- Round-robin fairness (RR=1): all 4 valid continuously, out_ready=1, channel i data = 8'h10+i -> out_ch sequence 0,1,2,3,0,1... out_data 10,11,12,13,10..., one per cycle with no bubbles.
- Fixed priority (RR=0): in_valid=4'b1010 held -> out_ch is always 1. Channel 3 is never granted until in_valid[1]=0.
- Backpressure: out_ready=0 for 3 cycles while out_valid=1 and out_data=8'h3C -> data and ch stable, in_ready=0, ptr unchanged. out_ready=1 then loads the next word in the same cycle.
- Non-power-of-two wrap: NCH=3, RR=1, in_valid=3'b101 -> grants 0,2,0,2. The pointer wraps from 2 to 0 and never selects a nonexistent index 3.
